// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit that owns the HI/LO pair.
// MULT/MULTU/DIV/DIVU run one shift-add or restoring-divide step per cycle.
// The cycle after the last step writes the sign-corrected result to HI/LO.
// MTHI/MTLO write directly while the unit is not calculating.
// Optional macro MULDIV_FAST_MUL_EN: multiplies finish in one cycle and never
// assert busy. Divides are unchanged.
module muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_fin;      // all steps done; next CALC cycle writes HI/LO
    logic                r_is_div;
    logic                r_neg_q;    // operand signs differ: negate product/quotient
    logic                r_neg_r;    // dividend negative: negate remainder
    logic                r_dvz;      // divisor was zero
    logic [DATA_W-1:0]   r_a;        // multiplier / dividend, becomes product low / quotient
    logic [DATA_W-1:0]   r_b;        // multiplicand / divisor magnitude
    logic [DATA_W-1:0]   r_acc;      // product high / partial remainder
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    // Request decode and operand magnitudes (0x80000000 maps to unsigned 2^31)
    logic                w_accept;
    logic                w_arith;
    logic                w_signed;
    logic                w_neg1;
    logic                w_neg2;
    logic [DATA_W-1:0]   w_mag1;
    logic [DATA_W-1:0]   w_mag2;

    assign w_accept = start && (r_state != S_CALC);
    assign w_arith  = ~op[2];
    assign w_signed = ~op[0];
    assign w_neg1   = w_signed & in1[DATA_W-1];
    assign w_neg2   = w_signed & in2[DATA_W-1];
    assign w_mag1   = w_neg1 ? -in1 : in1;
    assign w_mag2   = w_neg2 ? -in2 : in2;

    // One multiply step: conditionally add multiplicand, shift {acc,a} right
    logic [DATA_W:0]     w_sum;
    assign w_sum = {1'b0, r_acc} + (r_a[0] ? {1'b0, r_b} : '0);

    // One restoring-divide step: shift in the next dividend bit, subtract if it fits
    logic [DATA_W:0]     w_shift;
    logic                w_ge;
    logic [DATA_W-1:0]   w_rem;
    assign w_shift = {r_acc, r_a[DATA_W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_b});
    assign w_rem   = w_shift[DATA_W-1:0] - (w_ge ? r_b : '0);

    // Unsigned product magnitude
    logic [PROD_W-1:0]   w_mag_prod;
`ifdef MULDIV_FAST_MUL_EN
    assign w_mag_prod = {{DATA_W{1'b0}}, r_a} * {{DATA_W{1'b0}}, r_b};
`else
    assign w_mag_prod = {r_acc, r_a};
`endif

    // Sign correction of the finished result
    logic [PROD_W-1:0]   w_prod;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_remd;
    logic [DATA_W-1:0]   w_res_hi;
    logic [DATA_W-1:0]   w_res_lo;
    assign w_prod   = r_neg_q ? -w_mag_prod : w_mag_prod;
    assign w_quot   = r_dvz ? '1 : (r_neg_q ? -r_a : r_a);
    assign w_remd   = r_neg_r ? -r_acc : r_acc;
    assign w_res_hi = r_is_div ? w_remd : w_prod[PROD_W-1:DATA_W];
    assign w_res_lo = r_is_div ? w_quot : w_prod[DATA_W-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: DONE behaves like IDLE for new requests
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_state_next = (w_accept && w_arith) ? S_CALC : S_IDLE;
            S_CALC:         if (r_fin) w_state_next = S_DONE;
            default:        w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, result write, MTHI/MTLO
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_fin    <= 1'b0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dvz    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (r_state == S_CALC) begin
            if (r_fin) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else begin
                if (r_is_div) begin
                    r_acc <= w_rem;
                    r_a   <= {r_a[DATA_W-2:0], w_ge};
                end else begin
                    r_acc <= w_sum[DATA_W:1];
                    r_a   <= {w_sum[0], r_a[DATA_W-1:1]};
                end
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == '1) begin
                    r_fin <= 1'b1;
                end
            end
        end else if (w_accept) begin
            if (w_arith) begin
                r_a      <= w_mag1;
                r_b      <= w_mag2;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_is_div <= op[1];
                r_neg_q  <= w_neg1 ^ w_neg2;
                r_neg_r  <= w_neg1;
                r_dvz    <= (in2 == '0);
`ifdef MULDIV_FAST_MUL_EN
                r_fin    <= ~op[1];
`else
                r_fin    <= 1'b0;
`endif
            end else if (!op[1]) begin
                if (op[0]) begin
                    r_lo <= in1;
                end else begin
                    r_hi <= in1;
                end
            end
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    assign busy = (r_state == S_CALC) && r_is_div;
`else
    assign busy = (r_state == S_CALC);
`endif
    assign done = (r_state == S_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide responder for the EX stage; owns the HI/LO register pair.
- The EX stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests with a start pulse.
- The unit computes iteratively, raises busy while working and pulses done when HI/LO are updated.
- The hazard unit stalls MFHI/MFLO and any new request while busy=1.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == DATA_W.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  input  1  request valid; accepted only when busy=0.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
- in1  input  32  rs operand: multiplicand/dividend, or MTHI/MTLO data.
- in2  input  32  rt operand: multiplier/divisor.
- busy  output  1  high while an arithmetic op is in progress.
- done  output  1  one-cycle pulse in the cycle HI/LO hold a new arithmetic result.
- hi  output  32  HI register (registered).
- lo  output  32  LO register (registered).

Behaviour:
- Reset (reset=0 at a rising edge): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
  - Reset mid-operation aborts the operation immediately; no partial result is written.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 with op MULT/MULTU/DIV/DIVU: latch operands and sign info, counter=0, go to CALC; busy=1 from the next cycle.
  - start=1 with MTHI/MTLO: hi (or lo) takes in1 at that edge; stay in IDLE; done stays 0.
  - op 110/111: no effect.
- CALC:
  - One iteration per cycle for 32 cycles: shift-add multiply, or restoring divide.
  - The divide works on the magnitudes for signed ops.
  - After the 32nd iteration (counter==31), go to DONE.
- DONE:
  - hi/lo take the sign-corrected result; done=1 and busy=0 for exactly this cycle.
  - Next state is IDLE.
  - start is also accepted in DONE and handled as in IDLE.
- Latency: start sampled at edge E0 -> busy=1 after E0 through E32 -> done=1 after E33, with hi/lo valid at the same time.
- start while busy=1: ignored entirely, including MTHI/MTLO. Stalling is the issuer's duty.
- Multiply: 64-bit product {hi,lo}.
  - Signed: operate on magnitudes; negate the 64-bit product if the signs differ.
- Divide: lo=quotient, hi=remainder.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero (any signedness): lo=32'hFFFFFFFF, hi=in1 as latched.
- Signed overflow, 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
- Operand magnitude of 32'h80000000: treat as unsigned 2^31; no overflow inside the datapath.
- Operands are latched at acceptance; later in1/in2 changes have no effect.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU compute in a single cycle: accepted at E0 -> DONE after E1 -> done=1 and hi/lo valid after E1.
  - busy is never asserted for multiplies.
  - Divides are unchanged.
- Undefined: multiplies are iterative with 33-cycle latency, as in Behaviour.

Test Plan:
1. MULT in1=32'hFFFFFFFF, in2=32'h00000003 -> after E33: hi=32'hFFFFFFFF, lo=32'hFFFFFFFD, done high one cycle; busy high after E0 through E32. With MULDIV_FAST_MUL_EN: same values after E1.
2. MULTU in1=in2=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
3. Division signs:
   - DIV -7/2 (32'hFFFFFFF9, 32'h00000002) -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
   - DIVU 7/2 -> lo=3, hi=1.
   - DIV 7/-2 -> lo=32'hFFFFFFFD, hi=1.
4. Division corners:
   - DIV 100/0 -> lo=32'hFFFFFFFF, hi=32'h00000064.
   - DIV 32'h80000000/32'hFFFFFFFF -> lo=32'h80000000, hi=0.
5. Handshake and reset:
   - DIVU 9/4 started; new start of MULT 2*2 at cycle 5 and MTHI 32'hAAAA at cycle 6 both ignored; result lo=2, hi=1.
   - Repeat and drive reset=0 at cycle 10 -> busy=0, done=0, hi=lo=0 next cycle; no done pulse afterwards.
6. Move-to and back-to-back:
   - MTLO in1=32'h00001234 in IDLE -> lo=32'h00001234 next cycle, done=0, busy=0, hi unchanged.
   - Start MULTU 3*5 in the DONE cycle of a prior op -> accepted; result lo=15, hi=0.
